// File: rtl/fir_cfg_pkg.sv
// fir_cfg_pkg
// Shared constants for the FIR configuration block: the AXI-Lite register
// map, the ap_ctrl bit positions, the tap count, the responder FSM states
// and the read-source selector.
package fir_cfg_pkg;

    localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
    localparam logic [11:0] ADDR_IER      = 12'h004;
    localparam logic [11:0] ADDR_LEN      = 12'h010;
    localparam logic [11:0] ADDR_TAP_BASE = 12'h020;

    localparam int AP_START_BIT = 0;
    localparam int AP_DONE_BIT  = 1;
    localparam int AP_IDLE_BIT  = 2;

    localparam int TAP_NUM = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_BRAM = 2'd1,
        ST_RD_DATA = 2'd2
    } cfg_state_t;

    // Where the pending read gets its data from.
    typedef enum logic [1:0] {
        RD_REG      = 2'd0,
        RD_TAP      = 2'd1,
        RD_TAP_BUSY = 2'd2
    } rd_kind_t;

endpackage

// File: rtl/fir_cfg_tap_mux.sv
// fir_cfg_tap_mux
// Combinational owner-select for the single tap BRAM port. While the engine
// is idle the host side drives the port; while it is busy the datapath owns
// it and can only read (write enable forced low, write data zero).
// Ports:
//   ap_idle                        - selects host (1) or core (0)
//   host_we/host_en/host_di/host_a - host-side port request
//   core_en/core_a                 - datapath read request
//   tap_we/tap_en/tap_di/tap_a     - resulting BRAM port
module fir_cfg_tap_mux #(
    parameter int AW = 12,
    parameter int DW = 32
) (
    input  logic          ap_idle,
    input  logic [3:0]    host_we,
    input  logic          host_en,
    input  logic [DW-1:0] host_di,
    input  logic [AW-1:0] host_a,
    input  logic          core_en,
    input  logic [AW-1:0] core_a,
    output logic [3:0]    tap_we,
    output logic          tap_en,
    output logic [DW-1:0] tap_di,
    output logic [AW-1:0] tap_a
);

    assign tap_we = ap_idle ? host_we : 4'h0;
    assign tap_en = ap_idle ? host_en : core_en;
    assign tap_di = ap_idle ? host_di : '0;
    assign tap_a  = ap_idle ? host_a  : core_a;

endmodule

// File: rtl/fir_axil_cfg.sv
// fir_axil_cfg
// AXI-Lite responder owning the FIR configuration space: ap_ctrl (0x00),
// data_length (0x10) and the tap coefficients (0x20 + 4k). Shares the tap
// BRAM port with the datapath and runs the ap_start/ap_done/ap_idle handshake.
// Optional feature macro: FIR_CFG_IRQ_EN adds the irq output and the interrupt
// enable register at 0x04 (bit0). Without it 0x04 reads 0 and ignores writes.
// Ports:
//   axis_clk, axis_rst_n            - clock, synchronous active-low reset
//   aw*/w*                          - write address/data channel (awready==wready)
//   ar*/r*                          - read address/data channel
//   tap_WE/tap_EN/tap_Di/tap_A/tap_Do - tap BRAM port (read latency 1)
//   core_tap_EN/core_tap_A          - datapath tap read request (used while busy)
//   ap_start                        - one-cycle start pulse to the datapath
//   core_done                       - one-cycle completion pulse from the datapath
//   data_length, ap_idle            - programmed sample count, engine idle status
//   irq                             - ap_done & ier, registered (FIR_CFG_IRQ_EN only)
//
// Handshake: a write is taken when awvalid&wvalid are sampled in IDLE; the
// cycle after, awready/wready pulse together for one cycle. A read is taken
// when arvalid is sampled in IDLE (writes win a tie); arready pulses the
// cycle after, and rvalid then stays high with rdata stable until rready is
// sampled high. Nothing new is accepted during a write pulse or a read.
module fir_axil_cfg
    import fir_cfg_pkg::*;
#(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = TAP_NUM
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   awvalid,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    input  logic [pDATA_WIDTH-1:0] wdata,
    output logic                   awready,
    output logic                   wready,
    input  logic                   arvalid,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   arready,
    output logic                   rvalid,
    output logic [pDATA_WIDTH-1:0] rdata,
    input  logic                   rready,
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    input  logic                   core_tap_EN,
    input  logic [pADDR_WIDTH-1:0] core_tap_A,
    output logic                   ap_start,
    input  logic                   core_done,
    output logic [pDATA_WIDTH-1:0] data_length,
    output logic                   ap_idle
`ifdef FIR_CFG_IRQ_EN
    ,
    output logic                   irq
`endif
);

    localparam logic [pADDR_WIDTH-1:0] A_CTRL    = pADDR_WIDTH'(ADDR_AP_CTRL);
    localparam logic [pADDR_WIDTH-1:0] A_IER     = pADDR_WIDTH'(ADDR_IER);
    localparam logic [pADDR_WIDTH-1:0] A_LEN     = pADDR_WIDTH'(ADDR_LEN);
    localparam logic [pADDR_WIDTH-1:0] A_TAP0    = pADDR_WIDTH'(ADDR_TAP_BASE);
    localparam logic [pADDR_WIDTH-1:0] A_TAP_END = A_TAP0 + pADDR_WIDTH'(4 * Tape_Num);

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= A_TAP0) && (a < A_TAP_END) && (a[1:0] == 2'b00);
    endfunction

    cfg_state_t state_q, state_d;
    rd_kind_t   rd_kind_q;

    logic                   wr_pulse_q;
    logic                   arready_q;
    logic                   rvalid_q;
    logic [pDATA_WIDTH-1:0] rdata_q;
    logic [pADDR_WIDTH-1:0] rd_addr_q;
    logic [3:0]             host_we_q;
    logic [pDATA_WIDTH-1:0] host_di_q;
    logic [pADDR_WIDTH-1:0] host_a_q;
    logic                   host_en;
    logic                   ap_start_q;
    logic                   ap_done_q;
    logic                   ap_idle_q;
    logic [pDATA_WIDTH-1:0] data_length_q;
    logic [pDATA_WIDTH-1:0] ctrl_val;
    logic [pDATA_WIDTH-1:0] rd_reg_val;
    logic [pDATA_WIDTH-1:0] rd_value;
    logic                   wr_accept;
    logic                   rd_accept;

`ifdef FIR_CFG_IRQ_EN
    logic ier_q;
    logic irq_q;
`endif

    // The write pulse cycle blocks acceptance so a host still holding
    // awvalid in that cycle is not taken twice.
    assign wr_accept = (state_q == ST_IDLE) && !wr_pulse_q && awvalid && wvalid;
    assign rd_accept = (state_q == ST_IDLE) && !wr_pulse_q && arvalid && !(awvalid && wvalid);

    // ---------------- FSM ----------------
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (rd_accept)
                    state_d = (is_tap(araddr) && ap_idle_q) ? ST_RD_BRAM : ST_RD_DATA;
            end
            // BRAM samples the address at the end of this cycle; data is
            // on tap_Do during the first RD_DATA cycle.
            ST_RD_BRAM: state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (rvalid_q && rready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- read data source ----------------
    always_comb begin
        ctrl_val = '0;
        ctrl_val[AP_START_BIT] = ap_start_q;
        ctrl_val[AP_DONE_BIT]  = ap_done_q;
        ctrl_val[AP_IDLE_BIT]  = ap_idle_q;

        rd_reg_val = '0;
        case (rd_addr_q)
            A_CTRL: rd_reg_val = ctrl_val;
            A_LEN:  rd_reg_val = data_length_q;
`ifdef FIR_CFG_IRQ_EN
            A_IER:  rd_reg_val = {{(pDATA_WIDTH-1){1'b0}}, ier_q};
`else
            A_IER:  rd_reg_val = '0;
`endif
            default: rd_reg_val = '0;
        endcase

        rd_value = rd_reg_val;
        case (rd_kind_q)
            RD_TAP:      rd_value = tap_Do;
            RD_TAP_BUSY: rd_value = '1;
            default:     rd_value = rd_reg_val;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            wr_pulse_q    <= 1'b0;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rd_addr_q     <= '0;
            rd_kind_q     <= RD_REG;
            host_we_q     <= 4'h0;
            host_di_q     <= '0;
            host_a_q      <= '0;
            ap_start_q    <= 1'b0;
            ap_done_q     <= 1'b0;
            ap_idle_q     <= 1'b1;
            data_length_q <= '0;
        end else begin
            wr_pulse_q <= wr_accept;
            arready_q  <= rd_accept;
            host_we_q  <= 4'h0;
            ap_start_q <= 1'b0;

            if (wr_accept) begin
                // Tap writes while busy are acknowledged but dropped.
                if (is_tap(awaddr) && ap_idle_q) begin
                    host_we_q <= 4'hF;
                    host_a_q  <= awaddr - A_TAP0;
                    host_di_q <= wdata;
                end
                if (awaddr == A_LEN && ap_idle_q)
                    data_length_q <= wdata;
                if (awaddr == A_CTRL && wdata[AP_START_BIT] && ap_idle_q) begin
                    ap_start_q <= 1'b1;
                    ap_idle_q  <= 1'b0;
                    ap_done_q  <= 1'b0;
                end
            end

            if (rd_accept) begin
                rd_addr_q <= araddr;
                if (!is_tap(araddr)) begin
                    rd_kind_q <= RD_REG;
                end else if (ap_idle_q) begin
                    rd_kind_q <= RD_TAP;
                    host_a_q  <= araddr - A_TAP0;
                end else begin
                    rd_kind_q <= RD_TAP_BUSY;
                end
            end

            // First RD_DATA cycle captures the data; it is then held until
            // the host takes it.
            if (state_q == ST_RD_DATA) begin
                if (!rvalid_q) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= rd_value;
                    if (rd_kind_q == RD_REG && rd_addr_q == A_CTRL)
                        ap_done_q <= 1'b0;
                end else if (rready) begin
                    rvalid_q <= 1'b0;
                end
            end

            // Last assignment: completion wins over clear-on-read.
            if (core_done) begin
                ap_done_q <= 1'b1;
                ap_idle_q <= 1'b1;
            end
        end
    end

    // BRAM enable: the write pulse cycle, or the single RD_BRAM cycle.
    assign host_en = (host_we_q != 4'h0) || (state_q == ST_RD_BRAM);

    fir_cfg_tap_mux #(
        .AW(pADDR_WIDTH),
        .DW(pDATA_WIDTH)
    ) u_tap_mux (
        .ap_idle(ap_idle_q),
        .host_we(host_we_q),
        .host_en(host_en),
        .host_di(host_di_q),
        .host_a (host_a_q),
        .core_en(core_tap_EN),
        .core_a (core_tap_A),
        .tap_we (tap_WE),
        .tap_en (tap_EN),
        .tap_di (tap_Di),
        .tap_a  (tap_A)
    );

`ifdef FIR_CFG_IRQ_EN
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            ier_q <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (wr_accept && awaddr == A_IER)
                ier_q <= wdata[0];
            irq_q <= ap_done_q & ier_q;
        end
    end
    assign irq = irq_q;
`endif

    assign awready     = wr_pulse_q;
    assign wready      = wr_pulse_q;
    assign arready     = arready_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign ap_start    = ap_start_q;
    assign ap_idle     = ap_idle_q;
    assign data_length = data_length_q;

endmodule

// File: tb/tb_fir_axil_cfg.sv
// tb_fir_axil_cfg
// Bench for fir_axil_cfg: directed register/tap/handshake scenarios, then a
// randomized mix of accesses checked against a register-map model, then a
// reset during a pending read. Tap BRAM is modelled here with a 1-cycle
// registered read.
module tb_fir_axil_cfg;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [11:0] awaddr = '0, araddr = '0, core_tap_A = '0;
    logic [31:0] wdata = '0;
    logic        core_tap_EN = 1'b0, core_done = 1'b0;
    logic        awready, wready, arready, rvalid, tap_EN, ap_start, ap_idle;
    logic [31:0] rdata, tap_Di, data_length;
    logic [31:0] tap_Do = '0;
    logic [3:0]  tap_WE;
    logic [11:0] tap_A;
`ifdef FIR_CFG_IRQ_EN
    logic        irq;
`endif

    fir_axil_cfg dut (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .awvalid(awvalid), .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata),
        .awready(awready), .wready(wready),
        .arvalid(arvalid), .araddr(araddr), .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rready(rready),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_Di(tap_Di), .tap_A(tap_A), .tap_Do(tap_Do),
        .core_tap_EN(core_tap_EN), .core_tap_A(core_tap_A),
        .ap_start(ap_start), .core_done(core_done),
        .data_length(data_length), .ap_idle(ap_idle)
`ifdef FIR_CFG_IRQ_EN
        , .irq(irq)
`endif
    );

    // Tap BRAM: registered read, byte-address word index.
    logic [31:0] bram [0:1023] = '{default: '0};
    always @(posedge clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) bram[tap_A[11:2]] <= tap_Di;
            tap_Do <= bram[tap_A[11:2]];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_taps [11];
    logic [31:0] ref_len;
    logic        ref_idle, ref_done, ref_ier;

    function automatic bit tap_addr(input logic [11:0] a);
        return (a >= 12'h020) && (a <= 12'h048) && (a[1:0] == 2'b00);
    endfunction

    function automatic int tap_index(input logic [11:0] a);
        return (int'(a) - 32) / 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        if (a == 12'h000) return {29'd0, ref_idle, ref_done, 1'b0};
`ifdef FIR_CFG_IRQ_EN
        if (a == 12'h004) return {31'd0, ref_ier};
`endif
        if (a == 12'h010) return ref_len;
        if (tap_addr(a)) return ref_idle ? ref_taps[tap_index(a)] : 32'hFFFF_FFFF;
        return 32'd0;
    endfunction

    task automatic model_write(input logic [11:0] a, input logic [31:0] d);
        if (a == 12'h010 && ref_idle) ref_len = d;
        if (tap_addr(a) && ref_idle) ref_taps[tap_index(a)] = d;
`ifdef FIR_CFG_IRQ_EN
        if (a == 12'h004) ref_ier = d[0];
`endif
        if (a == 12'h000 && d[0] && ref_idle) begin
            ref_idle = 1'b0;
            ref_done = 1'b0;
        end
    endtask

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
        int n;
        logic       exp_start;
        logic [3:0] exp_we;
        exp_start = (a == 12'h000) && d[0] && ref_idle;
        exp_we    = (tap_addr(a) && ref_idle) ? 4'hF : 4'h0;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = d;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        check_eq("aw_latency", 32'(n), 32'd1);
        check_eq("wready", 32'(wready), 32'd1);
        check_eq("ap_start_pulse", 32'(ap_start), 32'(exp_start));
        check_eq("tap_we", 32'(tap_WE), 32'(exp_we));
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(a, d);
        @(posedge clk); #1;
        check_eq("awready_end", 32'(awready), 32'd0);
        check_eq("ap_start_end", 32'(ap_start), 32'd0);
        check_eq("ap_idle", 32'(ap_idle), 32'(ref_idle));
        check_eq("data_length", data_length, ref_len);
    endtask

    task automatic finish_read(input logic [31:0] exp, input int exp_gap,
                               input bit done_at_load, output logic [31:0] got);
        int m;
        int hold;
        if (done_at_load) core_done = 1'b1;
        m = 0;
        do begin @(posedge clk); #1; core_done = 1'b0; m++; end while (!rvalid && m < 20);
        check_eq("r_gap", 32'(m), 32'(exp_gap));
        check_eq("rdata", rdata, exp);
        got = rdata;
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_eq("rvalid_hold", 32'(rvalid), 32'd1);
            check_eq("rdata_hold", rdata, exp);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
        check_eq("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    task automatic axil_read(input logic [11:0] a, input bit done_at_load, output logic [31:0] got);
        int n;
        logic [31:0] exp;
        int exp_gap;
        exp = model_read(a);
        exp_gap = (tap_addr(a) && ref_idle) ? 2 : 1;
        arvalid = 1'b1; araddr = a;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        check_eq("ar_latency", 32'(n), 32'd1);
        arvalid = 1'b0;
        finish_read(exp, exp_gap, done_at_load, got);
        if (a == 12'h000) ref_done = 1'b0;
        if (done_at_load) begin
            ref_done = 1'b1;
            ref_idle = 1'b1;
        end
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        @(posedge clk); #1;
        core_done = 1'b0;
        ref_done = 1'b1;
        ref_idle = 1'b1;
        check_eq("idle_after_done", 32'(ap_idle), 32'd1);
        @(posedge clk); #1;
    endtask

    // Write and read offered together: the write must be taken first.
    task automatic write_read_same(input logic [11:0] a_w, input logic [31:0] d, input logic [11:0] a_r);
        int n;
        int m;
        logic [31:0] got;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = a_w; wdata = d;
        arvalid = 1'b1; araddr = a_r;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        check_eq("wr_first_latency", 32'(n), 32'd1);
        check_eq("ar_blocked", 32'(arready), 32'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        model_write(a_w, d);
        m = 0;
        do begin @(posedge clk); #1; m++; end while (!arready && m < 20);
        check_eq("rd_after_wr_latency", 32'(m), 32'd2);
        arvalid = 1'b0;
        finish_read(model_read(a_r), 1, 1'b0, got);
    endtask

    // ---------------- stimulus ----------------
    int taps_init [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
    logic [11:0] pool [12] = '{12'h000, 12'h000, 12'h004, 12'h008, 12'h010, 12'h014,
                               12'h020, 12'h024, 12'h03C, 12'h048, 12'h04C, 12'h100};

    initial begin
        logic [31:0] got;
        logic [11:0] a;
        int n;

        for (int k = 0; k < 11; k++) ref_taps[k] = 32'd0;
        ref_len = 32'd0; ref_idle = 1'b1; ref_done = 1'b0; ref_ier = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_awready", 32'(awready), 32'd0);
        check_eq("rst_wready", 32'(wready), 32'd0);
        check_eq("rst_arready", 32'(arready), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_tap_we", 32'(tap_WE), 32'd0);
        check_eq("rst_tap_en", 32'(tap_EN), 32'd0);
        check_eq("rst_tap_a", 32'(tap_A), 32'd0);
        check_eq("rst_tap_di", tap_Di, 32'd0);
        check_eq("rst_ap_start", 32'(ap_start), 32'd0);
        check_eq("rst_ap_idle", 32'(ap_idle), 32'd1);
        check_eq("rst_data_length", data_length, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Tap programming and readback
        for (int k = 0; k < 11; k++) axil_write(12'h020 + 12'(4 * k), 32'(taps_init[k]));
        for (int k = 0; k < 11; k++) begin
            axil_read(12'h020 + 12'(4 * k), 1'b0, got);
            check_eq("tap_readback", got, 32'(taps_init[k]));
        end

        // data_length
        axil_write(12'h010, 32'd600);
        axil_read(12'h010, 1'b0, got);
        check_eq("len_600", got, 32'd600);

        // Start, busy behaviour
        axil_write(12'h000, 32'd1);
        axil_read(12'h000, 1'b0, got);
        check_eq("ctrl_busy", got, 32'h0);
        axil_read(12'h024, 1'b0, got);
        check_eq("tap_busy", got, 32'hFFFF_FFFF);
        axil_write(12'h024, 32'd99);
        axil_write(12'h010, 32'd5);
        axil_write(12'h000, 32'd1);
        core_tap_EN = 1'b1; core_tap_A = 12'h028;
        #1;
        check_eq("core_tap_a", 32'(tap_A), 32'h028);
        check_eq("core_tap_en", 32'(tap_EN), 32'd1);
        check_eq("core_tap_we", 32'(tap_WE), 32'd0);
        core_tap_EN = 1'b0;

        // Completion coinciding with a clearing read: set wins
        axil_read(12'h000, 1'b1, got);
        check_eq("ctrl_race", got, 32'h0);
        axil_read(12'h000, 1'b0, got);
        check_eq("ctrl_done", got, 32'h6);
        axil_read(12'h000, 1'b0, got);
        check_eq("ctrl_cleared", got, 32'h4);

        // Plain start / done / clear-on-read
        axil_write(12'h000, 32'd1);
        pulse_done();
        axil_read(12'h000, 1'b0, got);
        check_eq("ctrl_done2", got, 32'h6);
        axil_read(12'h000, 1'b0, got);
        check_eq("ctrl_cleared2", got, 32'h4);
        axil_read(12'h024, 1'b0, got);
        check_eq("tap_kept", got, 32'hFFFF_FFF6);
        axil_read(12'h010, 1'b0, got);
        check_eq("len_kept", got, 32'd600);

        // Write and read in the same cycle
        write_read_same(12'h010, $urandom, 12'h010);

`ifdef FIR_CFG_IRQ_EN
        axil_write(12'h004, 32'd1);
        axil_write(12'h000, 32'd1);
        pulse_done();
        check_eq("irq_set", 32'(irq), 32'd1);
        axil_read(12'h004, 1'b0, got);
        check_eq("irq_hold", 32'(irq), 32'd1);
        axil_read(12'h000, 1'b0, got);
        check_eq("irq_clear", 32'(irq), 32'd0);
`endif

        // Randomized mix
        for (int it = 0; it < 80; it++) begin
            int r;
            r = $urandom_range(0, 9);
            a = pool[$urandom_range(0, 11)];
            core_tap_EN = 1'($urandom_range(0, 1));
            core_tap_A  = 12'($urandom_range(0, 11) * 4);
            if (r < 4) axil_write(a, (a == 12'h000) ? 32'($urandom_range(0, 3)) : $urandom);
            else if (r < 8) axil_read(a, 1'b0, got);
            else if (!ref_idle) pulse_done();
            else axil_read(12'h000, 1'b0, got);
`ifdef FIR_CFG_IRQ_EN
            check_eq("irq_model", 32'(irq), 32'(ref_done & ref_ier));
`endif
        end
        core_tap_EN = 1'b0;

        // Reset while read data is pending
        if (!ref_idle) pulse_done();
        axil_write(12'h010, 32'd1234);
        arvalid = 1'b1; araddr = 12'h010;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        arvalid = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!rvalid && n < 20);
        check_eq("pre_reset_rvalid", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("mid_rst_idle", 32'(ap_idle), 32'd1);
        check_eq("mid_rst_len", data_length, 32'd0);
        ref_len = 32'd0; ref_idle = 1'b1; ref_done = 1'b0; ref_ier = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("no_stale_rvalid", 32'(rvalid), 32'd0);
        end
        axil_read(12'h010, 1'b0, got);
        check_eq("len_after_rst", got, 32'd0);
        axil_read(12'h028, 1'b0, got);
        check_eq("tap_after_rst", got, ref_taps[2]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
